cache_ctrl: RTL and testbench
=============================

// Module: cache_ctrl
// PURPOSE
//   Direct-mapped, write-through, no-write-allocate L1 data cache and main-memory sequencer.
//   Sits between the single-cycle RISC-V core's load/store port and the 4-word-burst main memory.
//   Holds tag, valid and data arrays; stalls the core on every miss and every store.
//   Drives the memory's read_en/write_en for exactly 4 cycles per transaction.
// PARAMETERS
//   WIDTH  32    data word width
//   ADDR_W 10    word-address width, matches main memory $clog2(DEPTH)
//   LINES  32    cache lines, power of 2; line = 4 words; IDX_W=$clog2(LINES), TAG_W=ADDR_W-2-IDX_W
// PORTS
//   clk            in   1          clock, all state updates on posedge
//   reset          in   1          asynchronous, active-low
//   cpu_addr       in   ADDR_W     word address {tag,idx,off[1:0]}
//   cpu_rd         in   1          load request, level, held while stall=1
//   cpu_wr         in   1          store request, level, held while stall=1
//   cpu_wdata      in   WIDTH      store data
//   cpu_rdata      out  WIDTH      load data, valid when cpu_rd=1 and stall=0
//   stall          out  1          core must hold PC and request
//   mem_addr       out  ADDR_W     memory address (= cpu_addr)
//   mem_read_en    out  1          memory burst read enable
//   mem_write_en   out  1          memory write enable
//   mem_write_data out  WIDTH      = cpu_wdata
//   mem_ready      in   1          memory completion flag
//   mem_read_data  in   4*WIDTH    refill line; slice k = word at offset k
//   hit_cnt        out  16         load hits, saturating at 16'hFFFF
//   miss_cnt       out  16         load misses, saturating at 16'hFFFF
// BEHAVIOUR
//   Reset: all valid bits=0; state=IDLE; beat=0; hit_cnt=miss_cnt=0; mem enables=0; stall=0.
//   Data/tag arrays are not reset.
//   hit = valid[idx] && tag[idx]==cpu_addr tag field.
//   cpu_wr has priority when cpu_rd and cpu_wr are both 1.
//   FSM states: IDLE, RD_BURST, WR_BURST, RESP. Enables are Moore outputs.
//   IDLE:
//     - cpu_wr: stall=1 -> WR_BURST.
//     - cpu_rd & hit: stall=0; cpu_rdata=data[idx][off]; hit_cnt++.
//     - cpu_rd & !hit: stall=1; miss_cnt++ -> RD_BURST.
//     - no request: stall=0.
//   RD_BURST: mem_read_en=1, stall=1, beat counts 0..3; after beat 3 -> RESP.
//   WR_BURST: mem_write_en=1, stall=1, beat counts 0..3; after beat 3 -> RESP.
//   Bursts are exactly 4 cycles. Memory count is not resettable by the controller, so
//   enables must never stay high a 5th cycle.
//   RESP: enables=0, so memory clears ready at this edge.
//     - mem_ready=1:
//       - stall=0 -> IDLE.
//       - Read: cpu_rdata=slice off of mem_read_data (bypass); line, tag and valid written at the edge.
//       - Write: if hit, data[idx][off]<=cpu_wdata; on a miss the array is unchanged.
//     - mem_ready=0: stall=1, hold RESP (protocol fault; the bench flags it).
//   Latency: load hit 0 stall cycles; load miss or any store: stall high 5 cycles, released in cycle 6.
//   A store to the line being refilled cannot occur (core is stalled).
//   Back-to-back misses: RESP->IDLE guarantees one enable-low cycle between bursts.
//   Counters saturate; a store counts in neither counter.
//   Reset mid-burst: FSM returns to IDLE immediately, enables drop, and all lines become invalid.
//   Main memory shares the reset, so its counter realigns.
// TESTING
//   Load 0x040 after reset, memory words 0x40..0x43=A,B,C,D:
//     stall 5 cycles, enables high 4 cycles;
//     RESP cpu_rdata=A; miss_cnt=1.
//   Load 0x042 immediately after that: stall=0 same cycle, cpu_rdata=C, hit_cnt=1, no enables.
//   Store 0x041<=0x1234 (hit): mem_write_en exactly 4 cycles;
//     then load 0x041 -> 0x1234 with 0 stall.
//   Store to an uncached line (0x300): memory updated, valid unchanged; next load 0x300 misses.
//   Conflicting loads 0x040 then 0x240 (same idx, LINES=32) then 0x040: three misses, miss_cnt=3.
//   Reset in the 2nd RD_BURST cycle: enables drop asynchronously, valid cleared;
//     a reload of 0x040 returns correct A after 5 stall cycles.

Source files
------------

// File: rtl/cache_ctrl_if.sv
// Bus bundle between cache_ctrl, the core load/store port and the burst main memory.
interface cache_ctrl_if #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 10
);
  // Core side: cpu_rd/cpu_wr are level requests and stay stable with cpu_addr/cpu_wdata
  // for as long as stall=1; a request completes in the cycle where stall=0.
  logic [ADDR_W-1:0]  cpu_addr;
  logic               cpu_rd;
  logic               cpu_wr;
  logic [WIDTH-1:0]   cpu_wdata;
  logic [WIDTH-1:0]   cpu_rdata;
  logic               stall;
  logic [ADDR_W-1:0]  mem_addr;
  logic               mem_read_en;
  logic               mem_write_en;
  logic [WIDTH-1:0]   mem_write_data;
  logic               mem_ready;
  logic [4*WIDTH-1:0] mem_read_data;

  modport slave (
    input  cpu_addr, cpu_rd, cpu_wr, cpu_wdata, mem_ready, mem_read_data,
    output cpu_rdata, stall, mem_addr, mem_read_en, mem_write_en, mem_write_data
  );

  modport master (
    output cpu_addr, cpu_rd, cpu_wr, cpu_wdata, mem_ready, mem_read_data,
    input  cpu_rdata, stall, mem_addr, mem_read_en, mem_write_en, mem_write_data
  );
endinterface

// File: rtl/cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate L1 data cache with a 4-beat memory
// sequencer; stalls the core on every load miss and every store.
module cache_ctrl #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 10,
  parameter int LINES  = 32
) (
  input  logic         clk,
  input  logic         reset,
  cache_ctrl_if.slave  bus,
  output logic [15:0]  hit_cnt,
  output logic [15:0]  miss_cnt,
  output logic [1:0]   dbg_state_o
);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_W - 2 - IDX_W;

  typedef enum logic [1:0] {IDLE, RD_BURST, WR_BURST, RESP} state_t;

  state_t             state_q, state_d;
  logic [1:0]         beat_q, beat_d;
  logic               op_wr_q, op_wr_d;
  logic [LINES-1:0]   valid_q;
  logic [TAG_W-1:0]   tag_q  [LINES];
  logic [WIDTH-1:0]   data_q [LINES][4];
  logic [15:0]        hit_cnt_q, miss_cnt_q;

  logic [IDX_W-1:0]   idx;
  logic [TAG_W-1:0]   tag_f;
  logic [1:0]         off;
  logic               hit;
  logic               stall;
  logic [WIDTH-1:0]   rdata;
  logic               fill_en, wword_en, hit_inc, miss_inc;

  assign idx   = bus.cpu_addr[2 +: IDX_W];
  assign tag_f = bus.cpu_addr[ADDR_W-1 -: TAG_W];
  assign off   = bus.cpu_addr[1:0];
  assign hit   = valid_q[idx] && (tag_q[idx] == tag_f);

  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    op_wr_d  = op_wr_q;
    stall    = 1'b0;
    rdata    = '0;
    fill_en  = 1'b0;
    wword_en = 1'b0;
    hit_inc  = 1'b0;
    miss_inc = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.cpu_wr) begin
          stall   = 1'b1;
          op_wr_d = 1'b1;
          beat_d  = 2'd0;
          state_d = WR_BURST;
        end else if (bus.cpu_rd) begin
          if (hit) begin
            rdata   = data_q[idx][off];
            hit_inc = 1'b1;
          end else begin
            stall    = 1'b1;
            miss_inc = 1'b1;
            op_wr_d  = 1'b0;
            beat_d   = 2'd0;
            state_d  = RD_BURST;
          end
        end
      end
      RD_BURST, WR_BURST: begin
        stall  = 1'b1;
        beat_d = beat_q + 2'd1;
        if (beat_q == 2'd3) state_d = RESP;
      end
      RESP: begin
        // Enables are already low here, so the memory drops ready at the end of this cycle.
        if (bus.mem_ready) begin
          state_d = IDLE;
          if (!op_wr_q) begin
            rdata   = bus.mem_read_data[int'(off)*WIDTH +: WIDTH];
            fill_en = 1'b1;
          end else if (hit) begin
            wword_en = 1'b1;
          end
        end else begin
          stall = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      beat_q     <= 2'd0;
      op_wr_q    <= 1'b0;
      valid_q    <= '0;
      hit_cnt_q  <= 16'd0;
      miss_cnt_q <= 16'd0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      op_wr_q <= op_wr_d;
      if (fill_en) valid_q[idx] <= 1'b1;
      if (hit_inc && (hit_cnt_q != 16'hFFFF)) hit_cnt_q <= hit_cnt_q + 16'd1;
      if (miss_inc && (miss_cnt_q != 16'hFFFF)) miss_cnt_q <= miss_cnt_q + 16'd1;
    end
  end

  // Tag and data arrays carry no reset; valid_q alone decides whether they mean anything.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_q[idx] <= tag_f;
      for (int k = 0; k < 4; k++) begin
        data_q[idx][k] <= bus.mem_read_data[k*WIDTH +: WIDTH];
      end
    end else if (wword_en) begin
      data_q[idx][off] <= bus.cpu_wdata;
    end
  end

  assign bus.stall          = stall;
  assign bus.cpu_rdata      = rdata;
  assign bus.mem_addr       = bus.cpu_addr;
  assign bus.mem_write_data = bus.cpu_wdata;
  assign bus.mem_read_en    = (state_q == RD_BURST);
  assign bus.mem_write_en   = (state_q == WR_BURST);
  assign hit_cnt            = hit_cnt_q;
  assign miss_cnt           = miss_cnt_q;
  assign dbg_state_o        = state_q;
endmodule

// File: tb/tb_cache_ctrl.sv
// Directed bench for cache_ctrl: behavioural 4-beat memory, vector table and reset corner case.
module tb_cache_ctrl;
  localparam int WIDTH  = 32;
  localparam int ADDR_W = 10;
  localparam int LINES  = 32;
  localparam logic [31:0] WA = 32'hA0A0_A0A0;
  localparam logic [31:0] WB = 32'hB0B0_B0B0;
  localparam logic [31:0] WC = 32'hC0C0_C0C0;
  localparam logic [31:0] WD = 32'hD0D0_D0D0;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [9:0]  addr;
    logic [31:0] wdata;
    int          exp_stall;
    int          exp_en;
    logic [31:0] exp_rdata;
    logic [15:0] exp_hit;
    logic [15:0] exp_miss;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] hit_cnt, miss_cnt;
  logic [1:0]  dbg_state;
  int          checks = 0;
  int          errors = 0;
  logic [WIDTH-1:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  cache_ctrl_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus ();

  cache_ctrl #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .LINES(LINES)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .hit_cnt     (hit_cnt),
    .miss_cnt    (miss_cnt),
    .dbg_state_o (dbg_state)
  );

  // ---------------- main memory model ----------------
  logic [WIDTH-1:0] mem [1024];
  logic [1:0]       mcnt;
  logic             mready;

  function automatic logic [31:0] init_word(input logic [9:0] a);
    case (a)
      10'h040: return WA;
      10'h041: return WB;
      10'h042: return WC;
      10'h043: return WD;
      default: return 32'h5A5A_0000 | {22'd0, a};
    endcase
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mcnt   <= 2'd0;
      mready <= 1'b0;
      for (int i = 0; i < 1024; i++) mem[i] <= init_word(10'(i));
    end else if (bus.mem_read_en || bus.mem_write_en) begin
      mcnt <= mcnt + 2'd1;
      if (mcnt == 2'd3) begin
        mready <= 1'b1;
        if (bus.mem_write_en) mem[bus.mem_addr] <= bus.mem_write_data;
      end
    end else begin
      mready <= 1'b0;
    end
  end

  assign bus.mem_ready     = mready;
  assign bus.mem_read_data = {mem[{bus.mem_addr[9:2], 2'd3}], mem[{bus.mem_addr[9:2], 2'd2}],
                              mem[{bus.mem_addr[9:2], 2'd1}], mem[{bus.mem_addr[9:2], 2'd0}]};

  // ---------------- checking / driver tasks ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Called just after a posedge; returns just after the posedge that closes the access.
  task automatic do_access(input logic rd, input logic wr, input logic [9:0] addr,
                           input logic [31:0] wdata, output int stall_c, output int en_c,
                           output logic [31:0] rdata, output logic done);
    bus.cpu_addr  = addr;
    bus.cpu_rd    = rd;
    bus.cpu_wr    = wr;
    bus.cpu_wdata = wdata;
    stall_c = 0;
    en_c    = 0;
    rdata   = '0;
    done    = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      if (bus.mem_read_en || bus.mem_write_en) en_c++;
      if (bus.stall) stall_c++;
      else begin
        rdata = bus.cpu_rdata;
        done  = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    bus.cpu_rd = 1'b0;
    bus.cpu_wr = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int          sc, ec;
    logic [31:0] rdat;
    logic        done;
    logic [31:0] exp;
    if (v.rd && !v.wr) exp_q.push_back(v.exp_rdata);
    do_access(v.rd, v.wr, v.addr, v.wdata, sc, ec, rdat, done);
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_stall"}, sc, v.exp_stall);
    check({tag, "_en"}, ec, v.exp_en);
    if (v.rd && !v.wr) begin
      exp = exp_q.pop_front();
      check({tag, "_rdata"}, rdat, exp);
    end
    check({tag, "_hit"}, 32'(hit_cnt), 32'(v.exp_hit));
    check({tag, "_miss"}, 32'(miss_cnt), 32'(v.exp_miss));
    check({tag, "_en_gap"}, 32'({bus.mem_read_en, bus.mem_write_en}), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  vec_t vecs[10];
  vec_t post[3];

  initial begin
    vecs[0] = '{1'b1, 1'b0, 10'h040, 32'h0,         5, 4, WA,           16'd0, 16'd1};
    vecs[1] = '{1'b1, 1'b0, 10'h042, 32'h0,         0, 0, WC,           16'd1, 16'd1};
    vecs[2] = '{1'b0, 1'b1, 10'h041, 32'h0000_1234, 5, 4, 32'h0,        16'd1, 16'd1};
    vecs[3] = '{1'b1, 1'b0, 10'h041, 32'h0,         0, 0, 32'h0000_1234, 16'd2, 16'd1};
    vecs[4] = '{1'b0, 1'b1, 10'h300, 32'h0000_BEEF, 5, 4, 32'h0,        16'd2, 16'd1};
    vecs[5] = '{1'b1, 1'b0, 10'h300, 32'h0,         5, 4, 32'h0000_BEEF, 16'd2, 16'd2};
    vecs[6] = '{1'b1, 1'b0, 10'h301, 32'h0,         0, 0, 32'h5A5A_0301, 16'd3, 16'd2};
    vecs[7] = '{1'b1, 1'b1, 10'h043, 32'h0000_0077, 5, 4, 32'h0,        16'd3, 16'd2};
    vecs[8] = '{1'b1, 1'b0, 10'h043, 32'h0,         0, 0, 32'h0000_0077, 16'd4, 16'd2};
    vecs[9] = '{1'b1, 1'b0, 10'h040, 32'h0,         0, 0, WA,           16'd5, 16'd2};
    post[0] = '{1'b1, 1'b0, 10'h040, 32'h0,         5, 4, WA,           16'd0, 16'd1};
    post[1] = '{1'b1, 1'b0, 10'h240, 32'h0,         5, 4, 32'h5A5A_0240, 16'd0, 16'd2};
    post[2] = '{1'b1, 1'b0, 10'h040, 32'h0,         5, 4, WA,           16'd0, 16'd3};

    bus.cpu_addr  = '0;
    bus.cpu_rd    = 1'b0;
    bus.cpu_wr    = 1'b0;
    bus.cpu_wdata = '0;
    reset = 1'b1;
    #2 reset = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_stall", 32'(bus.stall), 32'd0);
    check("rst_rd_en", 32'(bus.mem_read_en), 32'd0);
    check("rst_wr_en", 32'(bus.mem_write_en), 32'd0);
    check("rst_hit", 32'(hit_cnt), 32'd0);
    check("rst_miss", 32'(miss_cnt), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 10; i++) run_vec(vecs[i], $sformatf("v%0d", i));

    // Reset asserted in the second read-burst cycle of a miss on 0x240.
    bus.cpu_addr = 10'h240;
    bus.cpu_rd   = 1'b1;
    @(negedge clk);
    check("mr_idle_stall", 32'(bus.stall), 32'd1);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    check("mr_burst2_rd_en", 32'(bus.mem_read_en), 32'd1);
    #2 reset = 1'b0;
    bus.cpu_rd = 1'b0;
    #1;
    check("mr_rd_en_drop", 32'(bus.mem_read_en), 32'd0);
    check("mr_stall_drop", 32'(bus.stall), 32'd0);
    check("mr_state_idle", 32'(dbg_state), 32'd0);
    check("mr_miss_clr", 32'(miss_cnt), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 3; i++) run_vec(post[i], $sformatf("p%0d", i));

    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end
endmodule
